// File: rtl/psum_accumulator.sv
// psum_accumulator
//   Output-side accumulation buffer for the PE mesh. Each accepted beat holds one
//   D-lane partial-sum vector. The beat either overwrites the addressed accumulator
//   entry (psumFirst) or adds into it with signed saturation. On the final pass
//   (psumLast) the result, with optional ReLU, is pushed into a small output FIFO.
//   A clear sweep zeroes one entry per cycle between layers.
//
// Ports
//   CLK, RST_N          : clock, asynchronous active-low reset
//   psumIn/psumAddr     : D x W signed lanes (lane i at [W*(i+1)-1 -: W]), target entry
//   psumFirst/psumLast  : overwrite instead of accumulate / emit result to FIFO
//   psumValid/psumReady : beat handshake
//   reluEn              : clamp negative emitted lanes to zero (stored value untouched)
//   clearReq            : pulse that starts the clear sweep
//   outData/outAddr     : FIFO head payload
//   outValid/outReady   : FIFO pop handshake
//   busy                : clear sweep in progress
//   satFlag             : sticky lane-saturation indicator
module psum_accumulator #(
  parameter int depth = 2,
  parameter int D     = (1 << depth),
  parameter int W     = 16,
  parameter int ADDR  = 4,
  parameter int FD    = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [W*D-1:0]    psumIn,
  input  logic [ADDR-1:0]   psumAddr,
  input  logic              psumFirst,
  input  logic              psumLast,
  input  logic              psumValid,
  output logic              psumReady,
  input  logic              reluEn,
  input  logic              clearReq,
  output logic [W*D-1:0]    outData,
  output logic [ADDR-1:0]   outAddr,
  output logic              outValid,
  input  logic              outReady,
  output logic              busy,
  output logic              satFlag
);

  localparam int NENT = 1 << ADDR;
  localparam int PW   = (FD > 1) ? $clog2(FD) : 1;
  localparam logic [ADDR-1:0] LAST_ENT = {ADDR{1'b1}};
  localparam logic [PW:0]     FULL_CNT = (PW+1)'(FD);

  typedef enum logic {ST_RUN = 1'b0, ST_CLEAR = 1'b1} state_e;

  state_e            state_q;
  logic [ADDR-1:0]   cnt_q;
  logic              sat_q;
  logic [W*D-1:0]    acc_q       [NENT];
  logic [W*D-1:0]    fifo_data_q [FD];
  logic [ADDR-1:0]   fifo_addr_q [FD];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [PW:0]       count_q;

  logic [W*D-1:0]    acc_rd_s;
  logic [W*D-1:0]    sum_d;
  logic [W*D-1:0]    emit_d;
  logic              sat_any_s;
  logic              accept_s;
  logic              push_s;
  logic              pop_s;

  // Signed add at W+1 bits. The MSB of the result flags saturation and the low W
  // bits hold the clamped sum. Overflow shows as bits W and W-1 disagreeing.
  function automatic logic [W:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    if (s[W] != s[W-1]) begin
      if (s[W]) begin
        sat_add = {1'b1, 1'b1, {(W-1){1'b0}}};
      end else begin
        sat_add = {1'b1, 1'b0, {(W-1){1'b1}}};
      end
    end else begin
      sat_add = {1'b0, s[W-1:0]};
    end
  endfunction

  // Ready ignores outReady on purpose: a pop in this cycle only frees space for the next one.
  assign psumReady = (state_q == ST_RUN) && !clearReq && (count_q < FULL_CNT);
  assign accept_s  = psumValid && psumReady;
  assign push_s    = accept_s && psumLast;
  assign pop_s     = outValid && outReady;

  assign outData   = fifo_data_q[rd_ptr_q];
  assign outAddr   = fifo_addr_q[rd_ptr_q];
  assign outValid  = (count_q != '0);
  assign busy      = (state_q == ST_CLEAR);
  assign satFlag   = sat_q;

  // Per-lane next accumulator value and ReLU-masked emit value for the offered beat
  always_comb begin
    logic [W:0] lane_s;
    lane_s    = '0;
    acc_rd_s  = acc_q[psumAddr];
    sum_d     = '0;
    emit_d    = '0;
    sat_any_s = 1'b0;
    for (int i = 0; i < D; i++) begin
      lane_s = sat_add(acc_rd_s[W*i +: W], psumIn[W*i +: W]);
      if (psumFirst) begin
        sum_d[W*i +: W] = psumIn[W*i +: W];
      end else begin
        sum_d[W*i +: W] = lane_s[W-1:0];
        sat_any_s       = sat_any_s | lane_s[W];
      end
      if (reluEn && sum_d[W*i+W-1]) begin
        emit_d[W*i +: W] = '0;
      end else begin
        emit_d[W*i +: W] = sum_d[W*i +: W];
      end
    end
  end

  // Control FSM: RUN/CLEAR, sweep counter and sticky saturation flag
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (clearReq) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
          end else if (accept_s && sat_any_s) begin
            sat_q   <= 1'b1;
          end
        end
        ST_CLEAR: begin
          cnt_q <= cnt_q + ADDR'(1);
          if (cnt_q == LAST_ENT) begin
            state_q <= ST_RUN;
          end
        end
        default: begin
          state_q <= ST_RUN;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Accumulator array: sweep zeroing in CLEAR, beat write-back in RUN (never both)
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NENT; i++) begin
        acc_q[i] <= '0;
      end
    end else if (state_q == ST_CLEAR) begin
      acc_q[cnt_q] <= '0;
    end else if (accept_s) begin
      acc_q[psumAddr] <= sum_d;
    end
  end

  // Output FIFO: circular buffer with wrapping pointers and an occupancy count
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < FD; i++) begin
        fifo_data_q[i] <= '0;
        fifo_addr_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) begin
        fifo_data_q[wr_ptr_q] <= emit_d;
        fifo_addr_q[wr_ptr_q] <= psumAddr;
        wr_ptr_q              <= wr_ptr_q + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
module tb_psum_accumulator;

  localparam int D = 4, W = 16, ADDR = 4, FD = 4, NENT = 16;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [63:0]   psumIn = '0;
  logic [3:0]    psumAddr = '0;
  logic          psumFirst = 1'b0, psumLast = 1'b0, psumValid = 1'b0;
  logic          psumReady;
  logic          reluEn = 1'b0, clearReq = 1'b0;
  logic [63:0]   outData;
  logic [3:0]    outAddr;
  logic          outValid;
  logic          outReady = 1'b1;
  logic          busy, satFlag;

  always #5 CLK = ~CLK;

  psum_accumulator dut (
    .CLK(CLK), .RST_N(RST_N), .psumIn(psumIn), .psumAddr(psumAddr),
    .psumFirst(psumFirst), .psumLast(psumLast), .psumValid(psumValid),
    .psumReady(psumReady), .reluEn(reluEn), .clearReq(clearReq),
    .outData(outData), .outAddr(outAddr), .outValid(outValid),
    .outReady(outReady), .busy(busy), .satFlag(satFlag)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  function automatic logic [63:0] all4(input int v);
    return pack4(v, v, v, v);
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [3:0]  a;
    logic [63:0] d;
  } ent_t;

  ent_t m_q[$];
  int   m_acc[NENT][D];
  bit   m_run = 1'b1;
  int   m_clear_left = 0;
  bit   m_sat = 1'b0;

  initial begin
    foreach (m_acc[e, l]) m_acc[e][l] = 0;
    forever begin
      @(posedge CLK or negedge RST_N);
      if (!RST_N) begin
        m_q.delete();
        foreach (m_acc[e, l]) m_acc[e][l] = 0;
        m_run = 1'b1;
        m_clear_left = 0;
        m_sat = 1'b0;
      end else begin
        bit   rdy;
        bit   do_pop;
        ent_t ne;
        int   x, s, ev;
        rdy    = m_run && !clearReq && (m_q.size() < FD);
        do_pop = (m_q.size() > 0) && outReady;
        if (do_pop) void'(m_q.pop_front());
        if (!m_run) begin
          for (int l = 0; l < D; l++) m_acc[NENT - m_clear_left][l] = 0;
          m_clear_left--;
          if (m_clear_left == 0) m_run = 1'b1;
        end else if (clearReq) begin
          m_run = 1'b0;
          m_clear_left = NENT;
          m_sat = 1'b0;
        end else if (psumValid && rdy) begin
          ne = '0;
          ne.a = psumAddr;
          for (int l = 0; l < D; l++) begin
            x = $signed(psumIn[16*l +: 16]);
            s = psumFirst ? x : m_acc[psumAddr][l] + x;
            if (s > 32767)  begin s = 32767;  m_sat = 1'b1; end
            if (s < -32768) begin s = -32768; m_sat = 1'b1; end
            m_acc[psumAddr][l] = s;
            ev = (reluEn && s < 0) ? 0 : s;
            ne.d[16*l +: 16] = ev[15:0];
          end
          if (psumLast) m_q.push_back(ne);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge CLK);
      chk("psumReady", psumReady, m_run && !clearReq && (m_q.size() < FD));
      chk("outValid", outValid, m_q.size() != 0);
      chk("busy", busy, !m_run);
      chk("satFlag", satFlag, m_sat);
      if (m_q.size() != 0) begin
        chk("outData", outData, m_q[0].d);
        chk("outAddr", outAddr, m_q[0].a);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [63:0] v, input int addr, input bit first, input bit last, input bit relu);
    bit got;
    got = 1'b0;
    psumIn = v; psumAddr = addr[3:0]; psumFirst = first; psumLast = last;
    reluEn = relu; psumValid = 1'b1;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge CLK);
      got = psumReady;
      @(posedge CLK);
      #1;
    end
    psumValid = 1'b0;
    chk("accept", got, 1);
  endtask

  initial begin
    int n;
    repeat (3) tick();
    RST_N = 1'b1;
    #1;
    chk("rst_outData", outData, 0);
    chk("rst_outAddr", outAddr, 0);
    chk("rst_ready", psumReady, 1);
    chk("rst_outValid", outValid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sat", satFlag, 0);

    // single pass with ReLU
    send(pack4(1, -2, 3, -4), 5, 1, 1, 1);
    chk("single_valid", outValid, 1);
    chk("single_data", outData, 64'h0000_0003_0000_0001);
    chk("single_addr", outAddr, 5);
    tick();
    chk("single_popped", outValid, 0);

    // three-pass accumulation, then a zero beat to re-read the entry
    send(all4(100), 2, 1, 0, 0);
    send(all4(100), 2, 0, 0, 0);
    send(all4(100), 2, 0, 1, 0);
    chk("accum_data", outData, 64'h012C_012C_012C_012C);
    chk("accum_sat", satFlag, 0);
    tick();
    send(all4(0), 2, 0, 1, 0);
    chk("accum_stored", outData, 64'h012C_012C_012C_012C);
    tick();

    // saturation both directions
    send(all4(30000), 7, 1, 0, 0);
    send(all4(10000), 7, 0, 1, 0);
    chk("sat_pos", outData, 64'h7FFF_7FFF_7FFF_7FFF);
    chk("sat_flag", satFlag, 1);
    tick();
    send(all4(-30000), 8, 1, 0, 0);
    send(all4(-10000), 8, 0, 1, 0);
    chk("sat_neg", outData, 64'h8000_8000_8000_8000);
    tick();

    // backpressure
    outReady = 1'b0;
    for (int k = 1; k <= 4; k++) send(all4(11 * k), k, 1, 1, 0);
    chk("full_ready", psumReady, 0);
    psumIn = all4(55); psumAddr = 4'd5; psumFirst = 1'b1; psumLast = 1'b1; psumValid = 1'b1;
    tick(); tick();
    chk("held_ready", psumReady, 0);
    chk("head_data", outData, 64'h000B_000B_000B_000B);
    chk("head_addr", outAddr, 1);
    outReady = 1'b1;
    send(all4(55), 5, 1, 1, 0);
    send(all4(66), 6, 1, 1, 0);
    repeat (8) tick();
    chk("drained", outValid, 0);

    // clear sweep
    send(all4(7), 0, 1, 0, 0);
    psumIn = all4(9); psumAddr = 4'd0; psumFirst = 1'b0; psumLast = 1'b1;
    psumValid = 1'b1; clearReq = 1'b1;
    @(negedge CLK);
    chk("clr_ready", psumReady, 0);
    tick();
    clearReq = 1'b0; psumValid = 1'b0;
    chk("busy_rise", busy, 1);
    chk("sat_cleared", satFlag, 0);
    n = 0;
    while (busy && n < 40) begin n++; tick(); end
    chk("busy_len", n, 16);
    chk("ready_back", psumReady, 1);
    send(all4(1), 0, 0, 1, 0);
    chk("after_clear", outData, 64'h0001_0001_0001_0001);
    tick();

    // reset in the middle of a sweep
    send(all4(50), 12, 1, 0, 0);
    outReady = 1'b0;
    send(all4(5), 3, 1, 1, 0);
    clearReq = 1'b1;
    tick();
    clearReq = 1'b0;
    repeat (4) tick();
    chk("mid_busy", busy, 1);
    chk("mid_fifo_kept", outValid, 1);
    RST_N = 1'b0;
    #2;
    chk("async_busy", busy, 0);
    tick();
    RST_N = 1'b1;
    #1;
    chk("rr_busy", busy, 0);
    chk("rr_ready", psumReady, 1);
    chk("rr_outValid", outValid, 0);
    outReady = 1'b1;
    send(all4(2), 12, 0, 1, 0);
    chk("rr_zeroed", outData, 64'h0002_0002_0002_0002);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/psum_accumulator.md
# psum_accumulator

Output-side accumulation buffer placed directly downstream of the convolutional PE mesh. It accepts one D-lane partial-sum vector per beat, one lane per mesh row. It accumulates each vector into an addressed entry across input-channel passes using signed saturating addition. On the final pass it applies optional ReLU and pushes the result into a small output FIFO for the write-back stage. A sequential clear sweep zeroes the whole accumulator array between layers.

## Interface
Parameters:
- depth, 2: log2 of mesh dimension.
- D, (1<<depth): lanes per beat, equal to mesh rows.
- W, 16: signed lane width.
- ADDR, 4: accumulator address width; 2^ADDR entries of D×W.
- FD, 4: output FIFO depth, a power of two.

Ports:
- CLK, input, 1: the single clock; all state is updated on its rising edge.
- RST_N, input, 1: asynchronous, active-low reset.
- psumIn, input, W*D: lane i is psumIn[W*(i+1)-1 -: W], two's complement.
- psumAddr, input, ADDR: target accumulator entry.
- psumFirst, input, 1: overwrite the entry instead of accumulating.
- psumLast, input, 1: final pass; emit the result to the FIFO.
- psumValid, input, 1: beat valid.
- psumReady, output, 1: beat accepted when psumValid && psumReady.
- reluEn, input, 1: clamp negative emitted lanes to 0; sampled with each beat.
- clearReq, input, 1: single-cycle pulse that starts the clear sweep.
- outData, output, W*D: FIFO head data, same lane packing as psumIn.
- outAddr, output, ADDR: entry address that belongs to outData.
- outValid, output, 1: FIFO not empty.
- outReady, input, 1: pop FIFO when outValid && outReady.
- busy, output, 1: high while in state CLEAR.
- satFlag, output, 1: sticky; set when any lane saturates; cleared by reset or clearReq.

## Operation
- FSM has two states, RUN and CLEAR. Reset enters RUN.
- RUN to CLEAR: occurs on an edge where clearReq=1. The sweep counter loads 0 and satFlag clears. Any beat offered in that cycle is not accepted.
- CLEAR: each cycle zeroes entry acc[cnt], then cnt increments. When cnt==2^ADDR-1, that entry is zeroed and the FSM returns to RUN. clearReq is ignored while in CLEAR. CLEAR lasts exactly 2^ADDR cycles.
- psumReady = (state==RUN) && !clearReq && (fifoCount<FD). It is not a function of outReady.
- Accepted beat, per lane: sum = psumFirst ? in : sat(acc[addr]+in). Addition is done at W+1 bits and clamped to [-2^(W-1), 2^(W-1)-1]. acc[addr] ← sum. The stored value is always pre-ReLU.
- Saturation sets satFlag. psumFirst never saturates.
- If psumLast: push {addr, reluEn ? max(sum,0) : sum} to the FIFO on the same edge. psumFirst and psumLast together is legal; it is a single-pass emit.
- Accumulator array: combinational read, write on the accept edge. Back-to-back beats to the same address therefore see the updated value with no hazard.
- FIFO: circular buffer with FD entries. Read and write pointers wrap modulo FD. Simultaneous push and pop when the FIFO is non-empty keeps the count unchanged. When the FIFO is full, psumReady=0, so no push is possible.
- clearReq does not flush the FIFO. The FIFO keeps draining during CLEAR.

## Timing
- Reset values: psumReady=1 after RST_N deasserts (RUN, FIFO empty); outValid=0; outData=0; outAddr=0; busy=0; satFlag=0. The accumulator array, FIFO, pointers and counters are all 0.
- Reset asserted mid-sweep or mid-stream returns the block to RUN immediately. FIFO contents are lost and the array is zeroed.
- Accept-to-output latency: a beat accepted with psumLast at edge t gives outValid=1 and valid outData from edge t onward, in cycle t+1.
- Throughput: one beat per cycle while the FIFO is not full.
- Pop at edge t: the next head, or outValid=0, appears in cycle t+1.
- busy rises in the cycle after the clearReq edge and falls after 2^ADDR cycles. psumReady returns in that same cycle.

## Test plan
- Reset then single pass: beat psumIn lanes {1,-2,3,-4}, addr 5, First=Last=1, reluEn=1, outReady=1 -> one cycle later outData={1,0,3,0}, outAddr=5, outValid for 1 cycle.
- Accumulation: three beats to addr 2 of all-lanes 100 (First, mid, Last), reluEn=0 -> outData all 300; acc[2]=300; satFlag=0.
- Saturation: First beat of 30000, then Last beat of 10000 to the same address -> lanes 32767, satFlag=1. Same test with -30000 and -10000 -> -32768.
- Backpressure: outReady=0, six back-to-back Last beats -> psumReady falls after 4 accepts. Release outReady -> entries pop in order, then beats 5 and 6 are accepted; no loss or duplication.
- Clear: accumulate 7 into addr 0, pulse clearReq concurrent with psumValid -> that beat is not accepted, busy=1 for 16 cycles, satFlag=0. A following non-First Last beat of 1 to addr 0 -> outData lanes 1.
- Reset mid-CLEAR at cycle 5 of the sweep -> busy=0, psumReady=1, outValid=0 immediately after RST_N rises.
